uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 113 +++++++++++
 tb/tb_uart_rx.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DEF_BAUD_CYCLES = 5208;
  localparam int FRAME_BITS      = 10;

  typedef enum logic {
    IDLE,
    RECEIVE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop RX synchronizer with falling-edge detect.
// Flops preset high so an idle line starts no frame.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_sync,
  output logic fall
);

  logic rx_meta;
  logic rx_prev;

  // Synchronize RX and keep one delayed copy for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with sticky ready flag.
// Samples each bit at its midpoint via a baud counter.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_CYCLES = DEF_BAUD_CYCLES,
  parameter int CNT_W       = $clog2(BAUD_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam logic [CNT_W-1:0] HALF_LD =
    CNT_W'(BAUD_CYCLES / 2);
  localparam logic [CNT_W-1:0] FULL_LD =
    CNT_W'(BAUD_CYCLES);
  localparam logic [3:0] LAST_BIT =
    4'(FRAME_BITS - 1);

  logic rx_sync;
  logic fall;

  rx_state_t        state,    state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_nxt;
  logic [3:0]       bit_cnt,  bit_nxt;
  logic [7:0]       shift,    shift_nxt;
  logic [7:0]       data_nxt;
  logic             rdy_nxt;
  logic             err_nxt;
  logic             baud_done;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .rx_sync (rx_sync),
    .fall    (fall)
  );

  // The count would hit zero on this clock: sample instead
  assign baud_done = (baud_cnt == CNT_W'(1));

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      rx_data  <= data_nxt;
      rdy      <= rdy_nxt;
      frm_err  <= err_nxt;
    end
  end

  // Next-state: start detect, bit sampling, frame close
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = rx_data;
    rdy_nxt   = rdy;
    err_nxt   = frm_err;

    if (clr_rdy) rdy_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = RECEIVE;
          baud_nxt  = HALF_LD;
          bit_nxt   = '0;
          rdy_nxt   = 1'b0;
          err_nxt   = 1'b0;
        end
      end
      RECEIVE: begin
        if (baud_done) begin
          shift_nxt = {rx_sync, shift[7:1]};
          baud_nxt  = FULL_LD;
          bit_nxt   = bit_cnt + 4'd1;
          if (bit_cnt == '0 && rx_sync) begin
            state_nxt = IDLE;
          end else if (bit_cnt == LAST_BIT) begin
            shift_nxt = shift;
            data_nxt  = shift;
            err_nxt   = ~rx_sync;
            rdy_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx.
// Drives serial frames and checks against a frame-level model.
module tb_uart_rx;

  localparam int B   = 20;
  localparam int H   = B / 2;
  localparam int LAT = H + 9 * B + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  logic [7:0] got_d[$];
  logic       got_e[$];
  int         got_c[$];
  logic       rdy_d = 1'b0;

  uart_rx #(.BAUD_CYCLES(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (rx),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every rdy rise with its data and cycle
  always @(negedge clk) begin
    if (rdy && !rdy_d) begin
      got_d.push_back(rx_data);
      got_e.push_back(frm_err);
      got_c.push_back(cyc);
    end
    rdy_d <= rdy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_got();
    got_d.delete();
    got_e.delete();
    got_c.delete();
  endtask

  function automatic logic fbit(input logic [7:0] d,
                                input logic stop,
                                input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return stop;
    return d[i-1];
  endfunction

  task automatic drive_bits(input logic [7:0] d,
                            input logic stop,
                            input int n);
    for (int i = 0; i < n; i++) begin
      rx = fbit(d, stop, i);
      tick(B);
    end
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input logic pulse,
                            output int t);
    t = cyc;
    drive_bits(d, stop, 9);
    rx = stop;
    if (pulse) begin
      tick(B - 2);
      clr_rdy = 1'b1;
      tick(1);
      clr_rdy = 1'b0;
      tick(1);
    end else begin
      tick(B);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    vecs++;
    if (rdy !== 1'b0) begin
      errs++;
      $display("FAIL reset_rdy got %b want 0", rdy);
    end
    vecs++;
    if (frm_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_err got %b want 0", frm_err);
    end
    vecs++;
    if (rx_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_data got %h want 00", rx_data);
    end
    rst_n = 1'b1;
    tick(2 * B);
    vecs++;
    if (rdy !== 1'b0 || got_d.size() != 0) begin
      errs++;
      $display("FAIL idle_after_reset rdy %b frames %0d want 0 0",
               rdy, got_d.size());
    end
  endtask

  task automatic test_loopback();
    int t;
    int lat;
    clear_got();
    send_frame(8'hA5, 1'b1, 1'b0, t);
    vecs++;
    if (got_d.size() != 1) begin
      errs++;
      $display("FAIL loop_count got %0d want 1", got_d.size());
    end else begin
      lat = got_c[0] - t;
      vecs++;
      if (got_d[0] !== 8'hA5) begin
        errs++;
        $display("FAIL loop_data got %h want a5", got_d[0]);
      end
      vecs++;
      if (got_e[0] !== 1'b0) begin
        errs++;
        $display("FAIL loop_err got %b want 0", got_e[0]);
      end
      vecs++;
      if (lat < LAT || lat > LAT + 3) begin
        errs++;
        $display("FAIL loop_latency got %0d want %0d..%0d",
                 lat, LAT, LAT + 3);
      end
    end
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    vecs++;
    if (rdy !== 1'b0) begin
      errs++;
      $display("FAIL loop_clr got %b want 0", rdy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pats[6];
    int ts[6];
    int lat;
    pats[0] = 8'h00;
    pats[1] = 8'hFF;
    pats[2] = 8'h01;
    pats[3] = 8'h80;
    pats[4] = 8'($urandom);
    pats[5] = 8'($urandom);
    clear_got();
    for (int i = 0; i < 6; i++) begin
      send_frame(pats[i], 1'b1, 1'b1, ts[i]);
      vecs++;
      if (rdy !== 1'b0) begin
        errs++;
        $display("FAIL b2b_clr[%0d] got %b want 0", i, rdy);
      end
    end
    vecs++;
    if (got_d.size() != 6) begin
      errs++;
      $display("FAIL b2b_count got %0d want 6", got_d.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        lat = got_c[i] - ts[i];
        vecs++;
        if (got_d[i] !== pats[i] || got_e[i] !== 1'b0 ||
            lat < LAT || lat > LAT + 3) begin
          errs++;
          $display("FAIL b2b[%0d] got %h/%b/%0d want %h/0/%0d",
                   i, got_d[i], got_e[i], lat, pats[i], LAT);
        end
      end
    end
  endtask

  task automatic test_clr_same_clock();
    logic [7:0] d;
    logic seen;
    d = 8'($urandom);
    seen = 1'b0;
    clr_rdy = 1'b1;
    drive_bits(d, 1'b1, 9);
    rx = 1'b1;
    for (int k = 0; k < B; k++) begin
      tick(1);
      if (rdy && clr_rdy) begin
        clr_rdy = 1'b0;
        seen = 1'b1;
      end
    end
    clr_rdy = 1'b0;
    vecs++;
    if (seen !== 1'b1) begin
      errs++;
      $display("FAIL set_wins got %b want 1", seen);
    end
    vecs++;
    if (rdy !== 1'b1 || rx_data !== d) begin
      errs++;
      $display("FAIL set_hold got %b/%h want 1/%h", rdy, rx_data, d);
    end
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    vecs++;
    if (rdy !== 1'b0) begin
      errs++;
      $display("FAIL clr_pulse got %b want 0", rdy);
    end
    tick(3);
    vecs++;
    if (rx_data !== d || rdy !== 1'b0) begin
      errs++;
      $display("FAIL clr_retain got %h/%b want %h/0",
               rx_data, rdy, d);
    end
  endtask

  task automatic test_glitch();
    int g;
    int t;
    int lat;
    clear_got();
    g = int'($urandom_range(1, H - 3));
    rx = 1'b0;
    tick(g);
    rx = 1'b1;
    tick(2 * B);
    vecs++;
    if (got_d.size() != 0 || rdy !== 1'b0) begin
      errs++;
      $display("FAIL glitch frames %0d rdy %b want 0 0",
               got_d.size(), rdy);
    end
    send_frame(8'h3C, 1'b1, 1'b0, t);
    vecs++;
    if (got_d.size() != 1) begin
      errs++;
      $display("FAIL glitch_next count %0d want 1", got_d.size());
    end else begin
      lat = got_c[0] - t;
      vecs++;
      if (got_d[0] !== 8'h3C || got_e[0] !== 1'b0 ||
          lat < LAT || lat > LAT + 3) begin
        errs++;
        $display("FAIL glitch_next got %h/%b/%0d want 3c/0/%0d",
                 got_d[0], got_e[0], lat, LAT);
      end
    end
  endtask

  task automatic test_break();
    int t;
    int lat;
    clear_got();
    send_frame(8'h5A, 1'b0, 1'b0, t);
    vecs++;
    if (got_d.size() != 1 || got_d[0] !== 8'h5A ||
        got_e[0] !== 1'b1 || rdy !== 1'b1) begin
      errs++;
      $display("FAIL stop_zero count %0d rdy %b want 1 1 (5a err 1)",
               got_d.size(), rdy);
    end
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    tick(12 * B);
    vecs++;
    if (got_d.size() != 1 || rdy !== 1'b0) begin
      errs++;
      $display("FAIL held_low count %0d rdy %b want 1 0",
               got_d.size(), rdy);
    end
    rx = 1'b1;
    tick(B);
    t = cyc;
    rx = 1'b0;
    tick(12 * B);
    vecs++;
    if (got_d.size() != 2) begin
      errs++;
      $display("FAIL break_count got %0d want 2", got_d.size());
    end else begin
      lat = got_c[1] - t;
      vecs++;
      if (got_d[1] !== 8'h00 || got_e[1] !== 1'b1 ||
          lat < LAT || lat > LAT + 3) begin
        errs++;
        $display("FAIL break got %h/%b/%0d want 00/1/%0d",
                 got_d[1], got_e[1], lat, LAT);
      end
    end
    rx = 1'b1;
    tick(2 * B);
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    logic [7:0] e;
    int t;
    d = 8'($urandom) | 8'h01;
    clear_got();
    send_frame(d, 1'b1, 1'b0, t);
    vecs++;
    if (got_d.size() != 1 || rx_data !== d) begin
      errs++;
      $display("FAIL pre_reset got %h want %h", rx_data, d);
    end
    e = {3'b111, 5'($urandom)};
    clear_got();
    drive_bits(e, 1'b1, 7);
    rx = 1'b1;
    tick(H);
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (rdy !== 1'b0 || rx_data !== 8'h00 || frm_err !== 1'b0) begin
      errs++;
      $display("FAIL async_reset got %b/%h/%b want 0/00/0",
               rdy, rx_data, frm_err);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(4 * B);
    vecs++;
    if (got_d.size() != 0 || rdy !== 1'b0 || rx_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_tail frames %0d rdy %b data %h want 0 0 00",
               got_d.size(), rdy, rx_data);
    end
    send_frame(8'hC3, 1'b1, 1'b0, t);
    vecs++;
    if (got_d.size() != 1 || rx_data !== 8'hC3 ||
        frm_err !== 1'b0) begin
      errs++;
      $display("FAIL post_reset got %h/%b count %0d want c3/0 1",
               rx_data, frm_err, got_d.size());
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_clr_same_clock();
    test_glitch();
    test_break();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
